conn_table_loader: RTL and testbench

- Downstream consumer of the binary config reader. On a load command it starts the reader and waits for the header. It then requests every connection record in turn and captures each one into an on-chip connection table.
- The populated table serves single-cycle peer-IP lookups to the packet datapath, returning peer MAC, ports and switch ID. Load progress and errors are reported through status outputs.

---
 rtl/conn_table_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_conn_table_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conn_table_loader.sv
// conn_table_loader: loads connection records from the config reader into an on-chip table
// and serves registered single-cycle peer-IP lookups against the valid entries.
module conn_table_loader #(
    parameter int MAX_ENTRIES    = 16,
    parameter int CNT_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    output logic                 cfg_start_read,
    input  logic                 cfg_busy,
    input  logic                 cfg_config_valid,
    input  logic                 cfg_parse_error,
    input  logic [31:0]          cfg_header_connections,
    output logic [5:0]           cfg_conn_index,
    output logic                 cfg_read_connection,
    input  logic                 cfg_conn_valid,
    input  logic [31:0]          cfg_conn_switch_id,
    input  logic [31:0]          cfg_conn_my_ip,
    input  logic [31:0]          cfg_conn_peer_ip,
    input  logic [15:0]          cfg_conn_my_port,
    input  logic [15:0]          cfg_conn_peer_port,
    input  logic [47:0]          cfg_conn_peer_mac,
    output logic                 table_ready,
    output logic                 load_error,
    output logic [1:0]           error_code,
    output logic                 table_overflow,
    output logic [CNT_WIDTH-1:0] entries_loaded,
    input  logic                 lkp_req,
    input  logic [31:0]          lkp_ip,
    output logic                 lkp_resp_valid,
    output logic                 lkp_hit,
    output logic [CNT_WIDTH-1:0] lkp_index,
    output logic [31:0]          lkp_switch_id,
    output logic [15:0]          lkp_my_port,
    output logic [15:0]          lkp_peer_port,
    output logic [47:0]          lkp_peer_mac
);
    localparam int AW = $clog2(MAX_ENTRIES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_HDR  = 3'd2;
    localparam logic [2:0] ISSUE     = 3'd3;
    localparam logic [2:0] WAIT_CONN = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;
    localparam logic [2:0] ERROR     = 3'd6;

    logic [2:0]             r_state;
    logic [TW-1:0]          r_tmo;
    logic                   r_iss;
    logic [CNT_WIDTH-1:0]   r_idx, r_target, r_loaded;
    logic                   r_start, r_rd, r_ready, r_err, r_ovf;
    logic [1:0]             r_code;
    logic [MAX_ENTRIES-1:0] r_valid;
    logic [31:0]            r_pip [MAX_ENTRIES];
    logic [31:0]            r_sw  [MAX_ENTRIES];
    logic [15:0]            r_mp  [MAX_ENTRIES];
    logic [15:0]            r_pp  [MAX_ENTRIES];
    logic [47:0]            r_mac [MAX_ENTRIES];
    logic                   r_lv, r_lh;
    logic [CNT_WIDTH-1:0]   r_li;
    logic [31:0]            r_lsw;
    logic [15:0]            r_lmp, r_lpp;
    logic [47:0]            r_lmac;

    logic                   w_wr, w_last, w_tmo, w_hdr_ovf, w_hit, w_unused;
    logic [CNT_WIDTH-1:0]   w_li;
    logic [31:0]            w_sw;
    logic [15:0]            w_mp, w_pp;
    logic [47:0]            w_mac;

    // the local IP is part of the record but not part of any lookup result
    assign w_unused  = ^cfg_conn_my_ip;
    assign w_wr      = r_state == WAIT_CONN && cfg_conn_valid && !load;
    assign w_last    = r_idx == r_target - 1'b1;
    assign w_tmo     = r_tmo == TW'(TIMEOUT_CYCLES - 1);
    assign w_hdr_ovf = cfg_header_connections > 32'(MAX_ENTRIES);

    assign cfg_start_read      = r_start;
    assign cfg_read_connection = r_rd;
    assign cfg_conn_index      = r_idx[5:0];
    assign table_ready         = r_ready;
    assign load_error          = r_err;
    assign error_code          = r_code;
    assign table_overflow      = r_ovf;
    assign entries_loaded      = r_loaded;
    assign lkp_resp_valid      = r_lv;
    assign lkp_hit             = r_lh;
    assign lkp_index           = r_li;
    assign lkp_switch_id       = r_lsw;
    assign lkp_my_port         = r_lmp;
    assign lkp_peer_port       = r_lpp;
    assign lkp_peer_mac        = r_lmac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tmo    <= '0;
            r_iss    <= 1'b0;
            r_idx    <= '0;
            r_target <= '0;
            r_loaded <= '0;
            r_start  <= 1'b0;
            r_rd     <= 1'b0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_code   <= 2'd0;
            r_valid  <= '0;
        end else begin
            r_start <= 1'b0;
            if (load) begin
                r_state  <= START;
                r_start  <= 1'b1;
                r_rd     <= 1'b0;
                r_tmo    <= '0;
                r_valid  <= '0;
                r_loaded <= '0;
                r_ready  <= 1'b0;
                r_err    <= 1'b0;
                r_code   <= 2'd0;
                r_ovf    <= 1'b0;
            end else begin
                case (r_state)
                    START: begin
                        r_state <= WAIT_HDR;
                        r_tmo   <= '0;
                    end
                    WAIT_HDR: begin
                        if (cfg_parse_error) begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            r_code  <= 2'd1;
                        end else if (cfg_config_valid && !cfg_busy) begin
                            r_target <= w_hdr_ovf ? CNT_WIDTH'(MAX_ENTRIES) : cfg_header_connections[CNT_WIDTH-1:0];
                            r_ovf    <= w_hdr_ovf;
                            r_idx    <= '0;
                            r_iss    <= 1'b0;
                            r_state  <= cfg_header_connections == 32'd0 ? DONE : ISSUE;
                            r_ready  <= cfg_header_connections == 32'd0;
                            r_rd     <= cfg_header_connections != 32'd0;
                        end else if (w_tmo) begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            r_code  <= 2'd2;
                        end else
                            r_tmo <= r_tmo + 1'b1;
                    end
                    ISSUE: begin
                        r_iss <= 1'b1;
                        if (r_iss) begin
                            r_rd    <= 1'b0;
                            r_state <= WAIT_CONN;
                            r_tmo   <= '0;
                        end
                    end
                    WAIT_CONN: begin
                        if (cfg_conn_valid) begin
                            r_valid[r_idx[AW-1:0]] <= 1'b1;
                            r_loaded <= r_idx + 1'b1;
                            r_idx    <= w_last ? r_idx : r_idx + 1'b1;
                            r_state  <= w_last ? DONE : ISSUE;
                            r_ready  <= w_last;
                            r_rd     <= !w_last;
                            r_iss    <= 1'b0;
                        end else if (w_tmo) begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            r_code  <= 2'd3;
                        end else
                            r_tmo <= r_tmo + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pip[r_idx[AW-1:0]] <= cfg_conn_peer_ip;
            r_sw[r_idx[AW-1:0]]  <= cfg_conn_switch_id;
            r_mp[r_idx[AW-1:0]]  <= cfg_conn_my_port;
            r_pp[r_idx[AW-1:0]]  <= cfg_conn_peer_port;
            r_mac[r_idx[AW-1:0]] <= cfg_conn_peer_mac;
        end
    end

    // descending scan so the lowest matching index is the one left standing
    always_comb begin
        w_hit = 1'b0;
        w_li  = '0;
        w_sw  = '0;
        w_mp  = '0;
        w_pp  = '0;
        w_mac = '0;
        for (int i = MAX_ENTRIES - 1; i >= 0; i--)
            if (r_valid[i] && r_pip[i] == lkp_ip) begin
                w_hit = 1'b1;
                w_li  = CNT_WIDTH'(i);
                w_sw  = r_sw[i];
                w_mp  = r_mp[i];
                w_pp  = r_pp[i];
                w_mac = r_mac[i];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lv   <= 1'b0;
            r_lh   <= 1'b0;
            r_li   <= '0;
            r_lsw  <= '0;
            r_lmp  <= '0;
            r_lpp  <= '0;
            r_lmac <= '0;
        end else begin
            r_lv   <= lkp_req;
            r_lh   <= lkp_req && w_hit;
            r_li   <= lkp_req ? w_li : '0;
            r_lsw  <= lkp_req ? w_sw : '0;
            r_lmp  <= lkp_req ? w_mp : '0;
            r_lpp  <= lkp_req ? w_pp : '0;
            r_lmac <= lkp_req ? w_mac : '0;
        end
    end
endmodule

// File: tb/tb_conn_table_loader.sv
// tb_conn_table_loader: directed bench acting as the config reader and the lookup client.
module tb_conn_table_loader;
    logic        clk = 1'b0;
    logic        rst_n, load, cfg_busy, cfg_config_valid, cfg_parse_error, cfg_conn_valid, lkp_req;
    logic [31:0] cfg_header_connections, cfg_conn_switch_id, cfg_conn_my_ip, cfg_conn_peer_ip, lkp_ip;
    logic [15:0] cfg_conn_my_port, cfg_conn_peer_port;
    logic [47:0] cfg_conn_peer_mac;
    logic        cfg_start_read, cfg_read_connection, table_ready, load_error, table_overflow;
    logic        lkp_resp_valid, lkp_hit;
    logic [5:0]  cfg_conn_index;
    logic [1:0]  error_code;
    logic [6:0]  entries_loaded, lkp_index;
    logic [31:0] lkp_switch_id;
    logic [15:0] lkp_my_port, lkp_peer_port;
    logic [47:0] lkp_peer_mac;
    logic [31:0] ips [0:19];
    int          n_tot = 0, n_pass = 0;

    conn_table_loader dut (
        .clk(clk), .rst_n(rst_n), .load(load), .cfg_start_read(cfg_start_read),
        .cfg_busy(cfg_busy), .cfg_config_valid(cfg_config_valid), .cfg_parse_error(cfg_parse_error),
        .cfg_header_connections(cfg_header_connections), .cfg_conn_index(cfg_conn_index),
        .cfg_read_connection(cfg_read_connection), .cfg_conn_valid(cfg_conn_valid),
        .cfg_conn_switch_id(cfg_conn_switch_id), .cfg_conn_my_ip(cfg_conn_my_ip),
        .cfg_conn_peer_ip(cfg_conn_peer_ip), .cfg_conn_my_port(cfg_conn_my_port),
        .cfg_conn_peer_port(cfg_conn_peer_port), .cfg_conn_peer_mac(cfg_conn_peer_mac),
        .table_ready(table_ready), .load_error(load_error), .error_code(error_code),
        .table_overflow(table_overflow), .entries_loaded(entries_loaded),
        .lkp_req(lkp_req), .lkp_ip(lkp_ip), .lkp_resp_valid(lkp_resp_valid), .lkp_hit(lkp_hit),
        .lkp_index(lkp_index), .lkp_switch_id(lkp_switch_id), .lkp_my_port(lkp_my_port),
        .lkp_peer_port(lkp_peer_port), .lkp_peer_mac(lkp_peer_mac)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic begin_load(input bit late, input bit perr, input int n);
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cfg_conn_valid = late;
        chk("start_pulse", cfg_start_read, 1);
        chk("clr_loaded", entries_loaded, 0);
        chk("clr_ready", table_ready, 0);
        @(negedge clk);
        cfg_conn_valid = 1'b0;
        chk("start_end", cfg_start_read, 0);
        cfg_parse_error = perr;
        cfg_config_valid = !perr;
        cfg_header_connections = n;
        @(negedge clk);
        cfg_parse_error = 1'b0;
        cfg_config_valid = 1'b0;
    endtask

    task automatic serve(input int i, input bit respond);
        int t = 0;
        while (cfg_read_connection !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rd_hi", cfg_read_connection, 1);
        chk("rd_idx", cfg_conn_index, i);
        @(negedge clk);
        chk("rd_hi2", cfg_read_connection, 1);
        chk("rd_idx2", cfg_conn_index, i);
        @(negedge clk);
        chk("rd_lo", cfg_read_connection, 0);
        if (respond) begin
            cfg_conn_peer_ip   = ips[i];
            cfg_conn_switch_id = 32'h100 + i;
            cfg_conn_my_port   = 16'h1000 + 16'(i);
            cfg_conn_peer_port = 16'h2000 + 16'(i);
            cfg_conn_peer_mac  = 48'h02AABB000000 + 48'(i);
            cfg_conn_valid     = 1'b1;
            @(negedge clk);
            cfg_conn_valid = 1'b0;
        end
    endtask

    task automatic lookup(input logic [31:0] ip, input bit hit, input int i);
        @(negedge clk);
        lkp_req = 1'b1;
        lkp_ip  = ip;
        @(negedge clk);
        lkp_req = 1'b0;
        chk("lkp_valid", lkp_resp_valid, 1);
        chk("lkp_hit", lkp_hit, hit);
        chk("lkp_index", lkp_index, hit ? i : 0);
        chk("lkp_sw", lkp_switch_id, hit ? 32'h100 + i : 0);
        chk("lkp_myport", lkp_my_port, hit ? 16'h1000 + 16'(i) : 16'h0);
        chk("lkp_peerport", lkp_peer_port, hit ? 16'h2000 + 16'(i) : 16'h0);
        chk("lkp_mac", lkp_peer_mac, hit ? 48'h02AABB000000 + 48'(i) : 48'h0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; load = 1'b0; cfg_busy = 1'b0; cfg_config_valid = 1'b0; cfg_parse_error = 1'b0;
        cfg_conn_valid = 1'b0; lkp_req = 1'b0; lkp_ip = '0; cfg_header_connections = '0;
        cfg_conn_switch_id = '0; cfg_conn_my_ip = 32'hC0A80001; cfg_conn_peer_ip = '0;
        cfg_conn_my_port = '0; cfg_conn_peer_port = '0; cfg_conn_peer_mac = '0;
        for (int i = 0; i < 20; i++) ips[i] = 32'h0A000001 + i;
        repeat (3) @(negedge clk);
        chk("rst_ready", table_ready, 0);
        chk("rst_err", load_error, 0);
        chk("rst_loaded", entries_loaded, 0);
        chk("rst_start", cfg_start_read, 0);
        chk("rst_lkp", lkp_resp_valid, 0);
        rst_n = 1'b1;

        begin_load(0, 0, 3);
        for (int i = 0; i < 3; i++) serve(i, 1);
        chk("l3_ready", table_ready, 1);
        chk("l3_loaded", entries_loaded, 3);
        chk("l3_err", load_error, 0);
        chk("l3_ovf", table_overflow, 0);
        lookup(32'h0A000002, 1, 1);
        lookup(32'h0B000000, 0, 0);
        @(negedge clk);
        lkp_req = 1'b1;
        lkp_ip  = 32'h0A000001;
        @(negedge clk);
        lkp_ip  = 32'h0A000003;
        chk("b2b_idx0", lkp_index, 0);
        chk("b2b_hit0", lkp_hit, 1);
        @(negedge clk);
        lkp_req = 1'b0;
        chk("b2b_idx2", lkp_index, 2);
        chk("b2b_valid2", lkp_resp_valid, 1);
        @(negedge clk);
        chk("lkp_idle", lkp_resp_valid, 0);

        begin_load(0, 1, 0);
        chk("perr_err", load_error, 1);
        chk("perr_code", error_code, 1);
        chk("perr_ready", table_ready, 0);
        chk("perr_loaded", entries_loaded, 0);

        begin_load(0, 0, 20);
        for (int i = 0; i < 16; i++) serve(i, 1);
        chk("ovf_ready", table_ready, 1);
        chk("ovf_flag", table_overflow, 1);
        chk("ovf_loaded", entries_loaded, 16);
        repeat (5) @(negedge clk);
        chk("ovf_no_more_rd", cfg_read_connection, 0);
        lookup(ips[15], 1, 15);

        begin_load(0, 0, 4);
        serve(0, 1);
        serve(1, 1);
        serve(2, 0);
        t = 0;
        while (!load_error && t < 1100) begin
            @(negedge clk);
            t++;
        end
        chk("tmo_cycles", t, 1024);
        chk("tmo_code", error_code, 3);
        chk("tmo_loaded", entries_loaded, 2);
        chk("tmo_ready", table_ready, 0);
        lookup(ips[0], 1, 0);
        lookup(ips[1], 1, 1);
        lookup(ips[2], 0, 0);

        begin_load(0, 0, 3);
        serve(0, 1);
        serve(1, 0);
        ips[2] = ips[0];
        begin_load(1, 0, 3);
        chk("rl_loaded0", entries_loaded, 0);
        for (int i = 0; i < 3; i++) serve(i, 1);
        chk("rl_ready", table_ready, 1);
        chk("rl_loaded", entries_loaded, 3);
        lookup(ips[0], 1, 0);
        lookup(ips[1], 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
